// File: rtl/ifq_pkg.sv
// Shared types and helpers for the multi-line instruction fetch queue.
// Default geometry below seeds the module parameters.
package ifq_pkg;

    typedef enum logic [0:0] {
        F_IDLE,
        F_WAIT
    } fetch_state_e;

    localparam int IFQ_LINE_WORDS  = 4;
    localparam int IFQ_DEPTH_LINES = 4;
    localparam int IFQ_INST_W      = 32;
    localparam int IFQ_ADDR_W      = 32;
    localparam int IFQ_LINE_BYTES  = IFQ_LINE_WORDS * 4;
    localparam int IFQ_OFF_W       = $clog2(IFQ_LINE_WORDS);
    localparam int IFQ_SLOT_W      = $clog2(IFQ_DEPTH_LINES);
    localparam int IFQ_CNT_W       = IFQ_SLOT_W + 1;

    // line_bytes must be a power of two.
    function automatic logic [63:0] align_line(input logic [63:0] addr, input int line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/ifq_line_buffer.sv
// Line-slot storage for the fetch queue: slot-valid bits, one-request
// reservation, slot-major word read pointer with start offset on flush.
module ifq_line_buffer
    import ifq_pkg::*;
#(
    parameter int LINE_WORDS  = IFQ_LINE_WORDS,
    parameter int DEPTH_LINES = IFQ_DEPTH_LINES,
    parameter int INST_W      = IFQ_INST_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [$clog2(LINE_WORDS)-1:0] flush_off,
    input  logic                         reserve,
    input  logic                         push,
    input  logic [LINE_WORDS*INST_W-1:0] push_line,
    input  logic                         pop,
    input  logic                         bypass,
    output logic [INST_W-1:0]            head,
    output logic                         empty,
    output logic                         full
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int SLOT_W = $clog2(DEPTH_LINES);
    localparam int CNT_W  = SLOT_W + 1;
    localparam int LINE_W = LINE_WORDS * INST_W;

    logic [LINE_W-1:0]      mem_q [DEPTH_LINES];
    logic [DEPTH_LINES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   resv_q, resv_d;
    logic [SLOT_W-1:0]      wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]      rd_slot_q, rd_slot_d;
    logic [OFF_W-1:0]       rd_word_q, rd_word_d;
    logic                   last_word;
    logic [LINE_W-1:0]      line_sel;
    logic [INST_W-1:0]      words [LINE_WORDS];

    assign last_word = (rd_word_q == OFF_W'(LINE_WORDS - 1));

    // Push sets before pop clears, so a bypassed line whose last word is
    // consumed in the same cycle leaves its slot free.
    always_comb begin
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        resv_d    = resv_q;
        wr_slot_d = wr_slot_q;
        rd_slot_d = rd_slot_q;
        rd_word_d = rd_word_q;
        if (flush) begin
            valid_d   = '0;
            cnt_d     = '0;
            resv_d    = 1'b0;
            wr_slot_d = '0;
            rd_slot_d = '0;
            rd_word_d = flush_off;
        end else begin
            if (reserve) resv_d = 1'b1;
            if (push) begin
                resv_d             = 1'b0;
                valid_d[wr_slot_q] = 1'b1;
                wr_slot_d          = wr_slot_q + SLOT_W'(1);
            end
            if (pop) begin
                if (last_word) begin
                    valid_d[rd_slot_q] = 1'b0;
                    rd_slot_d          = rd_slot_q + SLOT_W'(1);
                    rd_word_d          = '0;
                end else begin
                    rd_word_d = rd_word_q + OFF_W'(1);
                end
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop && last_word);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            cnt_q     <= '0;
            resv_q    <= 1'b0;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            rd_word_q <= '0;
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            resv_q    <= resv_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            rd_word_q <= rd_word_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH_LINES; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push && !flush && (wr_slot_q == SLOT_W'(gi))) mem_q[gi] <= push_line;
        end
    end

    assign line_sel = bypass ? push_line : mem_q[rd_slot_q];

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
        assign words[gi] = line_sel[gi*INST_W +: INST_W];
    end

    assign head  = words[rd_word_q];
    assign empty = ~|valid_q;
    assign full  = ((cnt_q + CNT_W'(resv_q)) == CNT_W'(DEPTH_LINES));

endmodule

// File: rtl/ifq_multiline.sv
// Instruction fetch queue top: fetch FSM, request/dispatch PCs, redirect.
// Define IFQ_BYPASS_EN to forward a returning line straight to inst when empty.
module ifq_multiline
    import ifq_pkg::*;
#(
    parameter int                LINE_WORDS  = IFQ_LINE_WORDS,
    parameter int                DEPTH_LINES = IFQ_DEPTH_LINES,
    parameter int                INST_W      = IFQ_INST_W,
    parameter int                ADDR_W      = IFQ_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDR_W-1:0]            pc_in,
    output logic                         cache_rd_en,
    output logic                         cache_abort,
    input  logic [LINE_WORDS*INST_W-1:0] dout,
    input  logic                         dout_valid,
    output logic [ADDR_W-1:0]            pc_out,
    output logic [INST_W-1:0]            inst,
    output logic                         empty,
    input  logic                         inst_rd_en,
    input  logic [ADDR_W-1:0]            jmp_branch_address,
    input  logic                         jmp_branch_valid
);

    localparam int                OFF_W      = $clog2(LINE_WORDS);
    localparam int                LINE_BYTES = LINE_WORDS * 4;
    localparam logic [ADDR_W-1:0] LINE_INC   = ADDR_W'(LINE_BYTES);
    localparam logic [ADDR_W-1:0] INST_INC   = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_in_q, pc_in_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              redirect;
    logic              push, pop, reserve, flush;
    logic              bypass_act;
    logic              buf_empty, buf_full;
    logic [OFF_W-1:0]  start_off;

    assign redirect  = jmp_branch_valid;
    assign start_off = jmp_branch_address[OFF_W+1:2];

`ifdef IFQ_BYPASS_EN
    assign bypass_act = !rst && buf_empty && (state_q == F_WAIT) && dout_valid && !redirect;
`else
    assign bypass_act = 1'b0;
`endif

    assign empty = buf_empty && !bypass_act;
    assign pop   = inst_rd_en && !empty && !redirect;

    always_comb begin
        state_d     = state_q;
        pc_in_d     = pc_in_q;
        pc_out_d    = pc_out_q;
        cache_rd_en = 1'b0;
        cache_abort = 1'b0;
        push        = 1'b0;
        reserve     = 1'b0;
        flush       = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (!redirect && !buf_full) begin
                    cache_rd_en = 1'b1;
                    reserve     = 1'b1;
                    state_d     = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect) begin
                    cache_abort = 1'b1;
                    state_d     = F_IDLE;
                end else if (dout_valid) begin
                    push    = 1'b1;
                    pc_in_d = pc_in_q + LINE_INC;
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
        if (redirect) begin
            flush    = 1'b1;
            pc_out_d = jmp_branch_address;
            pc_in_d  = ADDR_W'(align_line(64'(jmp_branch_address), LINE_BYTES));
        end else if (pop) begin
            pc_out_d = pc_out_q + INST_INC;
        end
        // A request in flight at reset is dropped without an abort.
        if (rst) begin
            cache_rd_en = 1'b0;
            cache_abort = 1'b0;
            reserve     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= F_IDLE;
            pc_in_q  <= RESET_PC;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_in_q  <= pc_in_d;
            pc_out_q <= pc_out_d;
        end
    end

    ifq_line_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .DEPTH_LINES(DEPTH_LINES),
        .INST_W     (INST_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .flush_off(start_off),
        .reserve  (reserve),
        .push     (push),
        .push_line(dout),
        .pop      (pop),
        .bypass   (bypass_act),
        .head     (inst),
        .empty    (buf_empty),
        .full     (buf_full)
    );

    assign pc_in  = pc_in_q;
    assign pc_out = pc_out_q;

endmodule

// File: tb/tb_ifq_multiline.sv
// Directed bench for ifq_multiline (default geometry: 4 words/line, 4 lines).
// Each word returned for line address A holds 0x100 + A/4 + word index.
module tb_ifq_multiline;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_in, pc_out, inst, jmp_branch_address;
    logic         cache_rd_en, cache_abort, dout_valid, empty, inst_rd_en, jmp_branch_valid;
    logic [127:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    ifq_multiline dut (
        .clk               (clk),
        .rst               (rst),
        .pc_in             (pc_in),
        .cache_rd_en       (cache_rd_en),
        .cache_abort       (cache_abort),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .pc_out            (pc_out),
        .inst              (inst),
        .empty             (empty),
        .inst_rd_en        (inst_rd_en),
        .jmp_branch_address(jmp_branch_address),
        .jmp_branch_valid  (jmp_branch_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] addr);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'h100 + (addr >> 2) + 32'(w);
        return l;
    endfunction

    task automatic push_line(input logic [31:0] addr);
        dout       = line_of(addr);
        dout_valid = 1'b1;
        step();
        dout_valid = 1'b0;
    endtask

    task automatic pop_check(input logic [31:0] pc);
        #1;
        check("pop_pc", pc_out, pc);
        check("pop_inst", inst, 32'h100 + (pc >> 2));
        check("pop_empty", empty, 1'b0);
        inst_rd_en = 1'b1;
        step();
        inst_rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; dout = '0; dout_valid = 1'b0; inst_rd_en = 1'b0;
        jmp_branch_address = '0; jmp_branch_valid = 1'b0;
        step(); step();
        check("rst_rd_en", cache_rd_en, 1'b0);
        check("rst_abort", cache_abort, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_pc_in", pc_in, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);

        // First request after reset, then none while the cache is silent.
        rst = 1'b0;
        #1;
        check("req0_rd_en", cache_rd_en, 1'b1);
        check("req0_pc_in", pc_in, 32'h0);
        check("req0_empty", empty, 1'b1);
        step(); check("wait_rd_en", cache_rd_en, 1'b0);
        step(); check("wait_rd_en", cache_rd_en, 1'b0);

        // Fill all four slots without popping.
        for (int l = 0; l < 4; l++) begin
            push_line(32'(l * 16));
            #1;
            check("fill_pc_in", pc_in, 32'((l + 1) * 16));
            check("fill_rd_en", cache_rd_en, (l < 3) ? 1'b1 : 1'b0);
            check("fill_empty", empty, 1'b0);
            if (l < 3) step();
        end
        step(); check("full_hold", cache_rd_en, 1'b0);

        // Drain 16 words; freeing slot 0 re-enables the 0x40 request.
        for (int k = 0; k < 16; k++) begin
            pop_check(32'(k * 4));
            if (k == 3) begin
                #1;
                check("refill_rd_en", cache_rd_en, 1'b1);
                check("refill_pc_in", pc_in, 32'h40);
            end
        end
        #1; check("drain_empty", empty, 1'b1);

        // Redirect to 0x48 during the 0x40 request; stale return is dropped.
        jmp_branch_address = 32'h48; jmp_branch_valid = 1'b1;
        #1;
        check("rdr_abort", cache_abort, 1'b1);
        check("rdr_rd_en", cache_rd_en, 1'b0);
        step();
        jmp_branch_valid = 1'b0; dout = {4{32'hDEAD_BEEF}}; dout_valid = 1'b1;
        #1;
        check("rdr_pc_out", pc_out, 32'h48);
        check("rdr_pc_in", pc_in, 32'h40);
        check("rdr_empty", empty, 1'b1);
        check("rdr_rd_en", cache_rd_en, 1'b1);
        check("rdr_no_abort", cache_abort, 1'b0);
        step();
        dout_valid = 1'b0;
        #1; check("stale_drop", empty, 1'b1);
        push_line(32'h40);
        #1; check("mid_line_inst", inst, 32'h112);
        pop_check(32'h48);
        pop_check(32'h4C);
        #1; check("mid_line_empty", empty, 1'b1);

        // Redirect with dout_valid in the same cycle (waiting on 0x50).
        jmp_branch_address = 32'h80; jmp_branch_valid = 1'b1;
        dout = line_of(32'h50); dout_valid = 1'b1;
        #1;
        check("same_abort", cache_abort, 1'b1);
        check("same_empty", empty, 1'b1);
        step();
        jmp_branch_valid = 1'b0; dout_valid = 1'b0;
        #1;
        check("same_empty2", empty, 1'b1);
        check("same_pc_out", pc_out, 32'h80);
        check("same_pc_in", pc_in, 32'h80);
        check("same_rd_en", cache_rd_en, 1'b1);

        // Redirect while idle: no abort, request follows; target is last word.
        jmp_branch_address = 32'h9C; jmp_branch_valid = 1'b1;
        #1;
        check("idle_abort", cache_abort, 1'b0);
        check("idle_rd_en", cache_rd_en, 1'b0);
        step();
        jmp_branch_valid = 1'b0;
        #1;
        check("idle_rd_en2", cache_rd_en, 1'b1);
        check("idle_pc_in", pc_in, 32'h90);
        check("idle_pc_out", pc_out, 32'h9C);
        step();
        dout = line_of(32'h90); dout_valid = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_empty", empty, 1'b0);
        check("byp_inst", inst, 32'h127);
`else
        check("lat_empty", empty, 1'b1);
`endif
        step();
        dout_valid = 1'b0;
        pop_check(32'h9C);
        #1;
        check("last_empty", empty, 1'b1);
        check("last_pc_out", pc_out, 32'hA0);

        // Fill three lines, reserve the fourth, then push it while popping
        // the last word of the head slot.
        for (int a = 0; a < 3; a++) begin
            push_line(32'hA0 + 32'(a * 16));
            #1;
            check("f5_pc_in", pc_in, 32'hB0 + 32'(a * 16));
            check("f5_rd_en", cache_rd_en, 1'b1);
            step();
        end
        pop_check(32'hA0);
        pop_check(32'hA4);
        pop_check(32'hA8);
        dout = line_of(32'hD0); dout_valid = 1'b1;
        #1;
        check("pp_pc_out", pc_out, 32'hAC);
        check("pp_inst", inst, 32'h12B);
        check("pp_rd_en", cache_rd_en, 1'b0);
        inst_rd_en = 1'b1;
        step();
        dout_valid = 1'b0; inst_rd_en = 1'b0;
        #1;
        check("pp_rd_en2", cache_rd_en, 1'b1);
        check("pp_pc_in", pc_in, 32'hE0);
        for (int p = 0; p < 12; p++) pop_check(32'hB0 + 32'(p * 4));
        #1; check("pp_empty", empty, 1'b1);

        // Return of 0xE0 into an empty buffer.
        dout = line_of(32'hE0); dout_valid = 1'b1;
`ifdef IFQ_BYPASS_EN
        inst_rd_en = 1'b1;
        #1;
        check("byp_empty", empty, 1'b0);
        check("byp_inst", inst, 32'h138);
        check("byp_pc_out", pc_out, 32'hE0);
        step();
        dout_valid = 1'b0;
        for (int w = 1; w < 4; w++) begin
            #1;
            check("byp_seq_pc", pc_out, 32'hE0 + 32'(w * 4));
            check("byp_seq_inst", inst, 32'h138 + 32'(w));
            step();
        end
        inst_rd_en = 1'b0;
`else
        #1;
        check("lat_empty2", empty, 1'b1);
        step();
        dout_valid = 1'b0;
        for (int w = 0; w < 4; w++) pop_check(32'hE0 + 32'(w * 4));
`endif
        #1; check("end_empty", empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifq_multiline.md
Name: ifq_multiline

Overview:
- Parametrised instruction fetch queue between the instruction cache and dispatch.
- Requests whole cache lines of LINE_WORDS instructions and buffers up to DEPTH_LINES lines.
- Delivers one instruction per pop together with its PC.
- Tracks the single outstanding cache request, aborts it on redirect, and discards stale returns; starts mid-line on unaligned redirect targets.

Parameters:
- LINE_WORDS, 4: instructions per cache line; power of two, 2..16.
- DEPTH_LINES, 4: line slots in the buffer; power of two, 2..16.
- INST_W, 32: instruction width in bits.
- ADDR_W, 32: PC width in bits; byte address, instructions 4-byte aligned.
- RESET_PC, 0: PC loaded by reset; must be line-aligned.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_in  out  ADDR_W  line-aligned address of the current or next cache request.
- cache_rd_en  out  1  request pulse; one cycle per request.
- cache_abort  out  1  kills the outstanding request; one-cycle pulse.
- dout  in  LINE_WORDS*INST_W  returned line; word 0 in the LSBs.
- dout_valid  in  1  dout valid this cycle.
- pc_out  out  ADDR_W  PC of inst.
- inst  out  INST_W  instruction at the queue head.
- empty  out  1  no instruction available.
- inst_rd_en  in  1  pop the head; ignored while empty.
- jmp_branch_address  in  ADDR_W  redirect target.
- jmp_branch_valid  in  1  redirect strobe.

Behaviour:
- Reset, synchronous, highest priority:
  - pc_in = pc_out = RESET_PC; cache_rd_en = 0; cache_abort = 0; empty = 1.
  - Buffer cleared; state = F_IDLE; start offset = 0.
  - Reset mid-request drops the request silently; no abort is issued and any later dout_valid is ignored.
- Fetch FSM, states F_IDLE and F_WAIT:
  - F_IDLE: cache_rd_en = 1 iff free slots > 0 and no redirect this cycle; then go to F_WAIT.
  - F_WAIT, dout_valid=1: push dout into a slot; pc_in += LINE_WORDS*4 with ADDR_W wrap; go to F_IDLE. The next request comes no earlier than the following cycle.
  - F_WAIT, redirect: cache_abort = 1 that cycle; go to F_IDLE. A dout_valid in the same cycle is discarded.
  - dout_valid in F_IDLE is ignored.
- Slot reservation:
  - A slot is reserved at request issue, so a returned line always has space and no overflow is possible.
  - full = all DEPTH_LINES slots valid or reserved.
- Read side:
  - Word read pointer walks slot-major.
  - inst = head word, combinational from storage.
  - Pop advances the pointer and does pc_out += 4; the slot is freed after its last word is popped.
  - empty = 1 iff no valid words remain.
  - Push and pop in the same cycle are both performed, including when full.
- Redirect, jmp_branch_valid=1, beats pop:
  - Flush all slots.
  - pc_out = target.
  - pc_in = target with the low log2(LINE_WORDS*4) bits cleared.
  - start offset = target[log2(LINE_WORDS)+1:2]. The first line pushed afterwards starts reading at that word; words below it are never presented.
  - empty = 1 next cycle.
  - A redirect while F_IDLE gives no abort; the request is issued the next cycle.
  - Back-to-back redirects: the last one wins.
- Latency, without bypass: a pushed word is visible at inst with empty = 0 one cycle after dout_valid.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When the buffer is empty and dout_valid arrives in F_WAIT without a redirect, inst = dout word[start offset] combinationally, pc_out unchanged, and empty = 0 in that same cycle.
  - A pop in that cycle consumes the word and pushes the remaining words.
  - If the consumed word was the line's last word, nothing is pushed and the reservation is released.
- Undefined: no combinational path from dout to inst or empty; one-cycle latency always.

Decomposition:
- Package ifq_pkg holds:
  - fetch_state_e {F_IDLE, F_WAIT};
  - localparams for line bytes, offset width and pointer widths, derived from the parameters;
  - a function align_line(addr).
- Sub-module ifq_line_buffer:
  - DEPTH_LINES x line storage with slot-valid bits, reservation counter, word read pointer, start offset and flush.
  - Outputs head word, empty and full.
  - The top level keeps the FSM, both PCs and the bypass.

Test Plan:
- Reset, then idle cache: cache_rd_en=1 at cycle 1 with pc_in=0; empty=1. With no dout_valid, no further request is issued.
- Four sequential lines returned with 0x100+i in each word, no pops: requests go to 0x0, 0x10, 0x20, 0x30, then cache_rd_en stays 0 (full). Popping 16 times yields pc_out 0x0..0x3C, and the first free slot re-enables the request to 0x40.
- Redirect to 0x48 in F_WAIT: cache_abort=1 that cycle and the stale dout_valid next cycle is dropped. The request goes to pc_in=0x40; after the return, the first inst is word 2 with pc_out=0x48.
- Redirect and dout_valid in the same cycle: line discarded, empty=1, abort=1.
- Full buffer with simultaneous pop and (impossible) push: count unchanged, no data loss, and the reservation never exceeds DEPTH_LINES.
- With IFQ_BYPASS_EN, empty buffer, dout_valid with inst_rd_en: inst equals dout[31:0] in the same cycle, and words 1..3 are popped on the following three cycles.
